// File: rtl/tof_pkg.sv
// Shared definitions for the histogram moving-average filter: default widths,
// the filter state encoding and the running-sum width helper.
package tof_pkg;

  localparam int AVG_DW   = 15;
  localparam int AVG_MAXW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } avg_state_e;

  // Three guard bits cover the largest window of eight full-scale samples.
  function automatic int sum_width(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/his_avg_filter_ring.sv
// Sample ring for the moving-average filter: one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module his_avg_ring
  import tof_pkg::*;
#(
  parameter  int DW    = AVG_DW,
  parameter  int DEPTH = AVG_MAXW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/his_avg_filter.sv
// Moving-average filter over the last 2^AVG_Win histogram peak samples,
// with valid/ready handshakes on both sides and a registered result.
module his_avg_filter
  import tof_pkg::*;
#(
  parameter int DW   = AVG_DW,
  parameter int MAXW = AVG_MAXW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          AVG_En,
  input  logic [1:0]    AVG_Win,
  input  logic [DW-1:0] HIS_Odata,
  input  logic          HIS_Ovalid,
  output logic          HIS_Oready,
  output logic [DW-1:0] AVG_Odata,
  output logic          AVG_Ovalid,
  input  logic          AVG_Oready
);

  localparam int SW = sum_width(DW);
  localparam int PW = $clog2(MAXW);

  avg_state_e    state;
  logic [1:0]    nreg;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [PW:0]   n_win;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] old_data;
  logic          accept;
  logic          result;

  assign HIS_Oready = AVG_En & (state != ST_IDLE) & (~AVG_Ovalid | AVG_Oready);
  assign accept     = HIS_Ovalid & HIS_Oready;
  assign n_win      = {{PW{1'b0}}, 1'b1} << nreg;
  // Oldest sample in the window; for a full-depth window this is the slot
  // about to be overwritten, read before the write lands.
  assign rd_ptr     = wr_ptr - n_win[PW-1:0];

  his_avg_ring #(
    .DW    (DW),
    .DEPTH (MAXW)
  ) u_ring (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (HIS_Odata),
    .raddr (rd_ptr),
    .rdata (old_data)
  );

  always_comb begin
    sum_nxt   = sum + SW'(HIS_Odata);
    count_nxt = (count == n_win) ? count : count + {{PW{1'b0}}, 1'b1};
    if (state == ST_RUN) sum_nxt = sum + SW'(HIS_Odata) - SW'(old_data);
    result = accept & (count_nxt == n_win);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      nreg       <= '0;
      count      <= '0;
      sum        <= '0;
      wr_ptr     <= '0;
      AVG_Odata  <= '0;
      AVG_Ovalid <= 1'b0;
    end else if (!AVG_En) begin
      state      <= ST_IDLE;
      count      <= '0;
      sum        <= '0;
      wr_ptr     <= '0;
      AVG_Ovalid <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        state <= ST_FILL;
        nreg  <= AVG_Win;
      end else if (accept) begin
        wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
        sum    <= sum_nxt;
        count  <= count_nxt;
        if (count_nxt == n_win) state <= ST_RUN;
      end

      if (result) begin
        AVG_Ovalid <= 1'b1;
        AVG_Odata  <= DW'(sum_nxt >> nreg);
      end else if (AVG_Oready) begin
        AVG_Ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_his_avg_filter.sv
// Scoreboard bench for his_avg_filter: stimulus queues hand-computed averages,
// an independent monitor pops and compares them at every output handshake.
module tb_his_avg_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        AVG_En;
  logic [1:0]  AVG_Win;
  logic [14:0] HIS_Odata;
  logic        HIS_Ovalid;
  logic        HIS_Oready;
  logic [14:0] AVG_Odata;
  logic        AVG_Ovalid;
  logic        AVG_Oready;

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q [$];

  his_avg_filter #(.DW(15), .MAXW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .AVG_En     (AVG_En),
    .AVG_Win    (AVG_Win),
    .HIS_Odata  (HIS_Odata),
    .HIS_Ovalid (HIS_Ovalid),
    .HIS_Oready (HIS_Oready),
    .AVG_Odata  (AVG_Odata),
    .AVG_Ovalid (AVG_Ovalid),
    .AVG_Oready (AVG_Oready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: one handshake per cycle where valid & ready are seen mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (AVG_Ovalid === 1'b1 && AVG_Oready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got 0x%0h with no result expected at %0t", AVG_Odata, $time);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("avg_out", AVG_Odata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Offer one sample; out/e give whether the accept must produce a result.
  task automatic send(input logic [14:0] d, input bit out, input logic [14:0] e);
    bit ok;
    ok = 1'b0;
    if (out) exp_q.push_back(e);
    HIS_Odata  = d;
    HIS_Ovalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (HIS_Oready) ok = 1'b1;
      @(negedge clk);
    end
    HIS_Ovalid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      #1;
      chk("valid_latency", AVG_Ovalid, out);
    end
  endtask

  task automatic restart(input logic [1:0] win);
    @(negedge clk);
    AVG_En = 1'b0;
    exp_q.delete();
    @(negedge clk);
    AVG_Win = win;
    AVG_En  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    AVG_En     = 1'b1;
    AVG_Win    = 2'd2;
    HIS_Odata  = '0;
    HIS_Ovalid = 1'b0;
    AVG_Oready = 1'b1;
    #1;
    chk("rst_ovalid", AVG_Ovalid, 0);
    chk("rst_odata",  AVG_Odata, 0);
    chk("rst_iready", HIS_Oready, 0);
    AVG_En = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Window 4 run
    restart(2'd2);
    send(15'd100, 0, 0);
    send(15'd200, 0, 0);
    send(15'd300, 0, 0);
    send(15'd400, 1, 15'd250);
    send(15'd500, 1, 15'd350);

    // Backpressure, window 2
    restart(2'd1);
    send(15'd10, 0, 0);
    AVG_Oready = 1'b0;
    send(15'd20, 1, 15'd15);
    exp_q.push_back(15'd25);
    HIS_Odata  = 15'd30;
    HIS_Ovalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_iready", HIS_Oready, 0);
      chk("bp_hold_data", AVG_Odata, 15'd15);
      chk("bp_hold_valid", AVG_Ovalid, 1);
      @(negedge clk);
    end
    AVG_Oready = 1'b1;
    #1;
    chk("bp_release_iready", HIS_Oready, 1);
    @(negedge clk);
    HIS_Ovalid = 1'b0;
    #1;
    chk("bp_valid_kept", AVG_Ovalid, 1);
    chk("bp_new_data", AVG_Odata, 15'd25);

    // Full-scale window 8, then one zero to exercise subtraction across the wrap
    restart(2'd3);
    for (int i = 0; i < 7; i++) send(15'h7FFF, 0, 0);
    send(15'h7FFF, 1, 15'h7FFF);
    send(15'h0000, 1, 15'h6FFF);

    // Window 1 pass-through
    restart(2'd0);
    send(15'h1234, 1, 15'h1234);
    send(15'h0001, 1, 15'h0001);

    // Truncation, window 2
    restart(2'd1);
    send(15'd1, 0, 0);
    send(15'd2, 1, 15'd1);
    send(15'd4, 1, 15'd3);

    // Enable drop partway through warm-up
    restart(2'd2);
    send(15'd1000, 0, 0);
    send(15'd2000, 0, 0);
    restart(2'd2);
    send(15'd8,  0, 0);
    send(15'd12, 0, 0);
    send(15'd16, 0, 0);
    send(15'd20, 1, 15'd14);

    // Reset mid-stream with a result pending, then resume
    restart(2'd2);
    AVG_Oready = 1'b0;
    send(15'd4,  0, 0);
    send(15'd8,  0, 0);
    send(15'd12, 0, 0);
    send(15'd16, 1, 15'd10);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_ovalid", AVG_Ovalid, 0);
    chk("midrst_odata",  AVG_Odata, 0);
    chk("midrst_iready", HIS_Oready, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    AVG_Oready = 1'b1;
    send(15'd40, 0, 0);
    send(15'd40, 0, 0);
    send(15'd40, 0, 0);
    send(15'd44, 1, 15'd41);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
